// File: rtl/ex_pipe_pkg.sv
// Shared widths, depth limits and stage-record layout for the execute propagation pipeline.
package ex_pipe_pkg;

    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned COND_CODE_W = 4;
    localparam int unsigned IM_ADDR_W   = 16;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned P_W         = 48;

    localparam int unsigned DEPTH_MIN = 2;
    localparam int unsigned DEPTH_MAX = 8;

    // Control strobes carried by every stage; packed MSB-first into the stage record.
    typedef struct packed {
        logic dm_we;
        logic dm_re;
        logic we_w;
        logic we_uhw;
        logic branchen;
        logic sr_we;
    } ex_strb_t;

    localparam int unsigned STRB_W = $bits(ex_strb_t);

    // Stage record layout, LSB first: rd | branch target | condition code | strobes.
    function automatic int unsigned ctrl_width(input int unsigned rd_w,
                                               input int unsigned cc_w,
                                               input int unsigned bt_w);
        return STRB_W + cc_w + bt_w + rd_w;
    endfunction

endpackage

// File: rtl/ex_pipe_stage.sv
// One execute stage register: a valid bit plus an opaque control record.
// kill clears only the valid bit; hold keeps both; otherwise the stage loads.
module ex_stage
    import ex_pipe_pkg::*;
#(
    parameter int unsigned W = ctrl_width(REG_ADDR_W, COND_CODE_W, IM_ADDR_W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold_i,
    input  logic         kill_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_d, valid_q;
    logic [W-1:0] data_d,  data_q;

    // Kill wins over hold so a flush can drop a stalled instruction.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (kill_i) begin
            valid_d = 1'b0;
        end else if (!hold_i) begin
            valid_d = valid_i;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/ex_pipe.sv
// Execute propagation pipeline: carries control fields DEPTH stages to writeback,
// selects the result word on entry to the last stage, and answers RAW hazard queries.
module ex_pipe
    import ex_pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned RD_W  = REG_ADDR_W,
    parameter int unsigned CC_W  = COND_CODE_W,
    parameter int unsigned BT_W  = IM_ADDR_W,
    parameter int unsigned DW    = DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_i,
    input  logic                       stall_i,
    input  logic                       flush_i,
    input  logic                       dm_we_i,
    input  logic                       dm_re_i,
    input  logic                       regfile_we_w_i,
    input  logic                       regfile_we_uhw_i,
    input  logic                       branchen_i,
    input  logic                       sr_we_i,
    input  logic [CC_W-1:0]            condcode_i,
    input  logic [BT_W-1:0]            branchtrgt_i,
    input  logic [RD_W-1:0]            addr_rd_i,
    input  logic [47:0]                p_i,
    input  logic [DW-1:0]              dm_regfile_data_i,
    input  logic [RD_W-1:0]            src_ra_i,
    input  logic [RD_W-1:0]            src_rb_i,
    output logic                       dm_we_o,
    output logic                       valid_o,
    output logic                       regfile_we_w_o,
    output logic                       regfile_we_uhw_o,
    output logic                       branchen_o,
    output logic                       sr_we_o,
    output logic [CC_W-1:0]            condcode_o,
    output logic [BT_W-1:0]            branchtrgt_o,
    output logic [RD_W-1:0]            regfile_addr_o,
    output logic [47:0]                p_o,
    output logic                       hazard_ra_o,
    output logic                       hazard_rb_o,
    output logic [$clog2(DEPTH+1)-1:0] inflight_o
);

    localparam int unsigned CW       = ctrl_width(RD_W, CC_W, BT_W);
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
    localparam int unsigned RD_LSB   = 0;
    localparam int unsigned BT_LSB   = RD_W;
    localparam int unsigned CC_LSB   = RD_W + BT_W;
    localparam int unsigned STRB_LSB = RD_W + BT_W + CC_W;

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("ex_pipe: DEPTH must lie in 2..8");
    end

    ex_strb_t      in_strb;
    logic [CW-1:0] in_data;

    logic          stg_valid [1:DEPTH];
    logic [CW-1:0] stg_data  [1:DEPTH];
    ex_strb_t      stg_strb  [1:DEPTH];

    logic [DEPTH-1:0] vld_vec;
    logic [DEPTH-1:0] hit_ra;
    logic [DEPTH-1:0] hit_rb;

    logic [P_W-1:0] p_d, p_q;

    always_comb begin
        in_strb.dm_we    = dm_we_i;
        in_strb.dm_re    = dm_re_i;
        in_strb.we_w     = regfile_we_w_i;
        in_strb.we_uhw   = regfile_we_uhw_i;
        in_strb.branchen = branchen_i;
        in_strb.sr_we    = sr_we_i;
    end

    assign in_data = {in_strb, condcode_i, branchtrgt_i, addr_rd_i};

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stg
        logic          prev_valid;
        logic [CW-1:0] prev_data;
        logic          hold;
        logic          kill;

        if (k == 1) begin : g_first
            assign prev_valid = valid_i;
            assign prev_data  = in_data;
        end else begin : g_next
            assign prev_valid = stg_valid[k-1];
            assign prev_data  = stg_data[k-1];
        end

        // Stall freezes the front and bubbles the last stage; flush kills the front
        // but lets the last stage retire what was in DEPTH-1.
        if (k < DEPTH) begin : g_front
            assign hold = stall_i;
            assign kill = flush_i;
        end else begin : g_last
            assign hold = 1'b0;
            assign kill = stall_i & ~flush_i;
        end

        ex_stage #(.W(CW)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .hold_i  (hold),
            .kill_i  (kill),
            .valid_i (prev_valid),
            .data_i  (prev_data),
            .valid_o (stg_valid[k]),
            .data_o  (stg_data[k])
        );

        assign stg_strb[k] = ex_strb_t'(stg_data[k][STRB_LSB +: STRB_W]);
        assign vld_vec[k-1] = stg_valid[k];
        assign hit_ra[k-1]  = stg_valid[k] & (stg_strb[k].we_w | stg_strb[k].we_uhw)
                            & (stg_data[k][RD_LSB +: RD_W] == src_ra_i);
        assign hit_rb[k-1]  = stg_valid[k] & (stg_strb[k].we_w | stg_strb[k].we_uhw)
                            & (stg_data[k][RD_LSB +: RD_W] == src_rb_i);
    end

    // Result word is captured as the instruction moves into the last stage.
    always_comb begin
        p_d = p_q;
        if (stg_valid[DEPTH-1] && (flush_i || !stall_i)) begin
            p_d = stg_strb[DEPTH-1].dm_re ? P_W'(dm_regfile_data_i) : p_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign dm_we_o          = stg_valid[1] & stg_strb[1].dm_we;
    assign valid_o          = stg_valid[DEPTH];
    assign regfile_we_w_o   = stg_valid[DEPTH] & stg_strb[DEPTH].we_w;
    assign regfile_we_uhw_o = stg_valid[DEPTH] & stg_strb[DEPTH].we_uhw;
    assign branchen_o       = stg_valid[DEPTH] & stg_strb[DEPTH].branchen;
    assign sr_we_o          = stg_valid[DEPTH] & stg_strb[DEPTH].sr_we;
    assign condcode_o       = stg_data[DEPTH][CC_LSB +: CC_W];
    assign branchtrgt_o     = stg_data[DEPTH][BT_LSB +: BT_W];
    assign regfile_addr_o   = stg_data[DEPTH][RD_LSB +: RD_W];
    assign p_o              = p_q;

    assign hazard_ra_o = |hit_ra;
    assign hazard_rb_o = |hit_rb;
    assign inflight_o  = CNT_W'($countones(vld_vec));

endmodule

// File: doc/ex_pipe.md
EX_PIPE -- requirements
Module: ex_pipe

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of execute propagation stages; legal range 2..8.
REQ-002 Parameter RD_W, default `reg_addr_width, SHALL set the destination-register address width.
REQ-003 Parameter CC_W, default `cond_code_width, SHALL set the condition-code width.
REQ-004 Parameter BT_W, default `im_addr_width, SHALL set the branch-target width.
REQ-005 Parameter DW, default `datawidth, SHALL set the memory-data width.
REQ-006 The block SHALL use one clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 valid_i  in  1  an instruction is presented this cycle.
REQ-010 stall_i  in  1  hold the pipeline.
REQ-011 flush_i  in  1  kill all non-final in-flight instructions.
REQ-012 dm_we_i, dm_re_i, regfile_we_w_i, regfile_we_uhw_i, branchen_i, sr_we_i  in  1 each  control strobes.
REQ-013 condcode_i  in  CC_W;  branchtrgt_i  in  BT_W;  addr_rd_i  in  RD_W.
REQ-014 p_i  in  48  ALU result, valid for the instruction currently in stage DEPTH-1.
REQ-015 dm_regfile_data_i  in  DW  load data, valid for the instruction currently in stage DEPTH-1.
REQ-016 src_ra_i, src_rb_i  in  RD_W  decode-stage source addresses for the hazard query.
REQ-017 dm_we_o  out  1  stage-1 qualified data-memory write.
REQ-018 valid_o, regfile_we_w_o, regfile_we_uhw_o, branchen_o, sr_we_o  out  1 each  final-stage qualified strobes.
REQ-019 condcode_o  out  CC_W;  branchtrgt_o  out  BT_W;  regfile_addr_o  out  RD_W;  p_o  out  48.
REQ-020 hazard_ra_o, hazard_rb_o  out  1  a matching in-flight write exists.
REQ-021 inflight_o  out  $clog2(DEPTH+1)  count of valid stages.

Function
REQ-022 Stages 1..DEPTH SHALL each register a valid bit plus all control fields; each advancing cycle, stage k SHALL load from stage k-1, and stage 1 SHALL load from the inputs (valid = valid_i).
REQ-023 Latency SHALL be exactly DEPTH cycles from valid_i to valid_o when no stall occurs.
REQ-024 Every output strobe SHALL equal its stage field ANDed with that stage's valid bit; dm_we_o SHALL use stage 1 and all other strobes SHALL use stage DEPTH.
REQ-025 On a valid, non-stalled advance into stage DEPTH, p_o SHALL load {zeros, dm_regfile_data_i} if the instruction has dm_re set, otherwise p_i.
REQ-026 While stall_i=1, stages 1..DEPTH-1 SHALL hold and stage DEPTH SHALL load a bubble (valid=0), so each instruction retires exactly once.
REQ-027 During a stall, inputs SHALL be ignored.
REQ-028 While flush_i=1, the valid bits of stages 1..DEPTH-1 SHALL clear at the next edge; stage DEPTH SHALL advance normally.
REQ-029 flush_i SHALL take priority over stall_i; flush with valid_i=1 SHALL drop the incoming instruction.
REQ-030 hazard_ra_o SHALL be combinational and equal to the OR, over all stages, of (valid & (we_w | we_uhw) & rd==src_ra_i); hazard_rb_o SHALL be the same using src_rb_i.
REQ-031 inflight_o SHALL be the combinational population count of the stage valid bits.
REQ-032 Invalid stages SHALL retain whatever field data they hold; only their valid bit is meaningful.

Reset
REQ-033 rst SHALL clear all valid bits, all stage fields and p_o to 0, so every output is 0 during and after reset.
REQ-034 rst SHALL dominate flush_i and stall_i, and mid-operation reset SHALL discard all in-flight instructions.

Structure
REQ-035 DEPTH limits and the stage-record field layout (control bundle width) SHALL live in a shared package/defines file next to defines.v.
REQ-036 A single sub-module, ex_stage (one stage register with valid, hold, and bubble/kill controls), SHALL be instantiated DEPTH times via generate.

Verification
REQ-037 DEPTH=4: valid_i=1, we_w=1, rd=5, p_i=0x123 in stage 3 -> regfile_we_w_o=1, regfile_addr_o=5, p_o=0x123 exactly 4 cycles later, for one cycle.
REQ-038 Load: dm_re=1, dm_regfile_data_i=0xDEADBEEF, p_i=0x7 -> p_o=0x0000DEADBEEF.
REQ-039 Stall 3 cycles with instructions in stages 1 and 2 -> valid_o=0 for those 3 cycles, inflight_o stays 2, then both retire in order, each once.
REQ-040 Flush with 4 valid stages -> next cycle inflight_o=0 except the stage-4 instruction retiring; flush+stall together behaves as flush.
REQ-041 rd=7 writer in stage 2, src_ra_i=7, src_rb_i=3 -> hazard_ra_o=1, hazard_rb_o=0; same with we_w=we_uhw=0 -> both 0.
REQ-042 Assert rst mid-stream for 1 cycle -> all outputs 0 the next cycle, and inflight_o=0.
